// File: rtl/compute_core_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : compute_core_ctrl
// Brief    : K-tile sequencer feeding weight rows and IA rows into compute_core.
// Revision : 1.0
// =============================================================================
module compute_core_ctrl #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CNT_W-1:0]           cfg_m_rows,
  input  logic [7:0]                 cfg_k_tiles,
  input  logic [SIZE*32-1:0]         bias_data,
  output logic                       busy,
  output logic                       done,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [SIZE*8-1:0]          w_data,
  input  logic                       ia_valid,
  output logic                       ia_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] ia_data,
  output logic                       core_store_weight_req,
  output logic [SIZE*8-1:0]          core_weight_in,
  output logic [SIZE*DATA_WIDTH-1:0] core_ia_vec_in,
  output logic                       core_ia_row_valid,
  output logic                       core_ia_is_init_data,
  output logic                       core_ia_calc_done,
  output logic [SIZE*32-1:0]         core_bias_in,
  input  logic                       core_partial_sum_calc_over,
  input  logic                       core_tile_calc_over
);

  localparam int                WCNT_W   = $clog2(SIZE) + 1;
  localparam logic [WCNT_W-1:0] C_W_LAST = WCNT_W'(SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_next;

  logic [WCNT_W-1:0]           r_w_cnt;
  logic [CNT_W-1:0]            r_m_cnt;
  logic [7:0]                  r_k_idx;
  logic [CNT_W-1:0]            r_cfg_m;
  logic [7:0]                  r_cfg_k;
  logic [SIZE*32-1:0]          r_bias;

  logic                        r_busy;
  logic                        r_done;
  logic                        r_store;
  logic [SIZE*8-1:0]           r_weight;
  logic                        r_row_valid;
  logic [SIZE*DATA_WIDTH-1:0]  r_vec;
  logic                        r_init;
  logic                        r_calc_done;

  logic                        w_w_hs;
  logic                        w_ia_hs;
  logic                        w_w_last;
  logic                        w_m_last;
  logic                        w_k_last;
  logic                        w_cfg_empty;
  logic                        w_start_acc;

  // Ready depends on state only, so no combinational path from valid exists.
  assign w_ready  = (r_state == S_LOAD_W);
  assign ia_ready = (r_state == S_STREAM);

  always_comb begin
    w_w_hs      = w_valid && (r_state == S_LOAD_W);
    w_ia_hs     = ia_valid && (r_state == S_STREAM);
    w_w_last    = (r_w_cnt == C_W_LAST);
    w_m_last    = (r_m_cnt == (r_cfg_m - CNT_W'(1)));
    w_k_last    = (r_k_idx == (r_cfg_k - 8'd1));
    w_cfg_empty = (cfg_m_rows == '0) || (cfg_k_tiles == 8'd0);
    w_start_acc = start && (r_state == S_IDLE);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_cfg_empty ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_w_hs && w_w_last) begin
          w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_ia_hs && w_m_last) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        // Only the completion matching this K-tile's position advances.
        if (w_k_last) begin
          if (core_tile_calc_over) begin
            w_next = S_DONE;
          end
        end else if (core_partial_sum_calc_over) begin
          w_next = S_LOAD_W;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_m <= '0;
      r_cfg_k <= 8'd0;
      r_bias  <= '0;
      r_k_idx <= 8'd0;
      r_w_cnt <= '0;
      r_m_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_cfg_m <= cfg_m_rows;
        r_cfg_k <= cfg_k_tiles;
        r_bias  <= bias_data;
        r_k_idx <= 8'd0;
      end else if ((r_state == S_WAIT) && !w_k_last && core_partial_sum_calc_over) begin
        r_k_idx <= r_k_idx + 8'd1;
      end

      if (w_w_hs) begin
        r_w_cnt <= w_w_last ? '0 : r_w_cnt + WCNT_W'(1);
      end

      if (w_ia_hs) begin
        r_m_cnt <= w_m_last ? '0 : r_m_cnt + CNT_W'(1);
      end
    end
  end

  // Core-facing strobes are one-cycle registered pulses; data is zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_store     <= 1'b0;
      r_weight    <= '0;
      r_row_valid <= 1'b0;
      r_vec       <= '0;
      r_init      <= 1'b0;
      r_calc_done <= 1'b0;
    end else begin
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      r_store     <= w_w_hs;
      r_weight    <= w_w_hs ? w_data : '0;
      r_row_valid <= w_ia_hs;
      r_vec       <= w_ia_hs ? ia_data : '0;
      r_init      <= w_ia_hs && (r_k_idx == 8'd0);
      r_calc_done <= (r_state == S_FLUSH);
    end
  end

  assign busy                  = r_busy;
  assign done                  = r_done;
  assign core_store_weight_req = r_store;
  assign core_weight_in        = r_weight;
  assign core_ia_vec_in        = r_vec;
  assign core_ia_row_valid     = r_row_valid;
  assign core_ia_is_init_data  = r_init;
  assign core_ia_calc_done     = r_calc_done;
  assign core_bias_in          = r_bias;

endmodule
`default_nettype wire

// File: tb/tb_compute_core_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_compute_core_ctrl
// Brief    : Randomized self-checking bench with a per-tile behavioural model.
// Revision : 1.0
// =============================================================================
module tb_compute_core_ctrl;

  localparam int SIZE = 4;
  localparam int DW   = 16;
  localparam int CW   = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [CW-1:0]       cfg_m_rows;
  logic [7:0]          cfg_k_tiles;
  logic [SIZE*32-1:0]  bias_data;
  logic                busy, done;
  logic                w_valid, w_ready;
  logic [SIZE*8-1:0]   w_data;
  logic                ia_valid, ia_ready;
  logic [SIZE*DW-1:0]  ia_data;
  logic                core_store_weight_req;
  logic [SIZE*8-1:0]   core_weight_in;
  logic [SIZE*DW-1:0]  core_ia_vec_in;
  logic                core_ia_row_valid, core_ia_is_init_data, core_ia_calc_done;
  logic [SIZE*32-1:0]  core_bias_in;
  logic                core_partial_sum_calc_over, core_tile_calc_over;

  always #5 clk = ~clk;

  compute_core_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .CNT_W(CW)) u_dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .start                      (start),
    .cfg_m_rows                 (cfg_m_rows),
    .cfg_k_tiles                (cfg_k_tiles),
    .bias_data                  (bias_data),
    .busy                       (busy),
    .done                       (done),
    .w_valid                    (w_valid),
    .w_ready                    (w_ready),
    .w_data                     (w_data),
    .ia_valid                   (ia_valid),
    .ia_ready                   (ia_ready),
    .ia_data                    (ia_data),
    .core_store_weight_req      (core_store_weight_req),
    .core_weight_in             (core_weight_in),
    .core_ia_vec_in             (core_ia_vec_in),
    .core_ia_row_valid          (core_ia_row_valid),
    .core_ia_is_init_data       (core_ia_is_init_data),
    .core_ia_calc_done          (core_ia_calc_done),
    .core_bias_in               (core_bias_in),
    .core_partial_sum_calc_over (core_partial_sum_calc_over),
    .core_tile_calc_over        (core_tile_calc_over)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_store, n_row, n_cdone, n_done;

  // Expected outputs after the next rising edge.
  logic                e_busy, e_done, e_wr, e_ir, e_store, e_row, e_init, e_cdone;
  logic [SIZE*8-1:0]   e_wdata;
  logic [SIZE*DW-1:0]  e_vec;
  logic [SIZE*32-1:0]  e_bias;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("busy",       128'(busy),                  128'(e_busy));
    check("done",       128'(done),                  128'(e_done));
    check("w_ready",    128'(w_ready),               128'(e_wr));
    check("ia_ready",   128'(ia_ready),              128'(e_ir));
    check("store_req",  128'(core_store_weight_req), 128'(e_store));
    check("weight_in",  128'(core_weight_in),        128'(e_wdata));
    check("row_valid",  128'(core_ia_row_valid),     128'(e_row));
    check("ia_vec",     128'(core_ia_vec_in),        128'(e_vec));
    check("init_data",  128'(core_ia_is_init_data),  128'(e_init));
    check("calc_done",  128'(core_ia_calc_done),     128'(e_cdone));
    check("bias",       128'(core_bias_in),          128'(e_bias));
  endtask

  task automatic clear_pulses();
    e_store = 1'b0; e_wdata = '0; e_row = 1'b0; e_vec = '0;
    e_init  = 1'b0; e_cdone = 1'b0; e_done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
    n_store += int'(core_store_weight_req);
    n_row   += int'(core_ia_row_valid);
    n_cdone += int'(core_ia_calc_done);
    n_done  += int'(done);
    clear_pulses();
  endtask

  task automatic noise();
    w_valid  = 1'($urandom_range(0, 1));
    w_data   = $urandom;
    ia_valid = 1'($urandom_range(0, 1));
    ia_data  = {$urandom, $urandom};
  endtask

  // One full tile run; abort_row >= 0 asserts reset after that many IA rows in K-tile 0.
  task automatic run_tile(input int m, input int k, input int abort_row, input bit gaps);
    int  acc, miss, nw;
    bit  v, last;
    n_store = 0; n_row = 0; n_cdone = 0; n_done = 0;
    noise();
    start       = 1'b1;
    cfg_m_rows  = CW'(m);
    cfg_k_tiles = 8'(k);
    bias_data   = {$urandom, $urandom, $urandom, $urandom};
    e_bias      = bias_data;
    e_busy      = 1'b1;
    if (m == 0 || k == 0) begin
      e_done = 1'b1;
      step();
      start = 1'b0; bias_data = ~bias_data; noise();
      e_busy = 1'b0;
      step();
      noise(); step();
      check("zero_cfg_stores", 128'(n_store), 128'(0));
      check("zero_cfg_done",   128'(n_done),  128'(1));
      return;
    end
    e_wr = 1'b1;
    step();
    start = 1'b0;
    bias_data = {$urandom, $urandom, $urandom, $urandom};
    for (int kt = 0; kt < k; kt++) begin
      acc = 0; miss = 0;
      while (acc < SIZE) begin
        noise();
        v = (!gaps || miss >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        w_valid = v;
        if (v) begin
          e_store = 1'b1; e_wdata = w_data; acc++; miss = 0;
          if (acc == SIZE) begin e_wr = 1'b0; e_ir = 1'b1; end
        end else miss++;
        step();
      end
      acc = 0; miss = 0;
      while (acc < m) begin
        noise();
        v = (!gaps || miss >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        ia_valid = v;
        if (v) begin
          e_row = 1'b1; e_vec = ia_data; e_init = (kt == 0); acc++; miss = 0;
          if (acc == m) e_ir = 1'b0;
        end else miss++;
        step();
        if (abort_row >= 0 && kt == 0 && acc == abort_row) begin
          #2 rst_n = 1'b0;
          #1;
          e_busy = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_bias = '0;
          clear_pulses();
          check_all();
          start = 1'b0; w_valid = 1'b0; ia_valid = 1'b0;
          step(); step();
          rst_n = 1'b1;
          check("abort_no_done", 128'(n_done), 128'(0));
          return;
        end
      end
      noise();
      e_cdone = 1'b1;
      step();
      last = (kt == k - 1);
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) begin
        noise();
        start       = 1'($urandom_range(0, 1));
        cfg_m_rows  = CW'($urandom_range(0, 9));
        cfg_k_tiles = 8'($urandom_range(0, 4));
        core_tile_calc_over        = !last && (i == 0);
        core_partial_sum_calc_over = last && (i == 0);
        step();
      end
      noise();
      start = 1'b0;
      core_tile_calc_over        = last;
      core_partial_sum_calc_over = !last;
      if (last) e_done = 1'b1; else e_wr = 1'b1;
      step();
      core_tile_calc_over = 1'b0; core_partial_sum_calc_over = 1'b0;
    end
    noise();
    e_busy = 1'b0;
    step();
    w_valid = 1'b0; ia_valid = 1'b0;
    check("store_count", 128'(n_store), 128'(SIZE * k));
    check("row_count",   128'(n_row),   128'(m * k));
    check("cdone_count", 128'(n_cdone), 128'(k));
    check("done_count",  128'(n_done),  128'(1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1;
    cfg_m_rows = CW'(3); cfg_k_tiles = 8'd1;
    bias_data = {$urandom, $urandom, $urandom, $urandom};
    w_valid = 1'b1; w_data = '0; ia_valid = 1'b1; ia_data = '0;
    core_partial_sum_calc_over = 1'b0; core_tile_calc_over = 1'b0;
    e_busy = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_bias = '0;
    clear_pulses();
    repeat (3) step();
    rst_n = 1'b1;

    run_tile(3, 1, -1, 1'b0);
    run_tile(2, 3, -1, 1'b0);
    repeat (6) run_tile($urandom_range(1, 6), $urandom_range(1, 3), -1, 1'b1);
    run_tile(0, 2, -1, 1'b0);
    run_tile(3, 0, -1, 1'b0);
    run_tile(5, 1, 2, 1'b0);
    run_tile(5, 1, -1, 1'b1);
    run_tile(1, 2, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
